// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer for the execute stage: fixed-latency multiply,
// 32-step restoring divide, valid/ready result handshake, busy stall request and flush abort.
module mdu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;
  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_CNT_INIT = 5'(W - 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV_RUN, DIV_FIX, DONE} state_t;

  state_t         state_reg, state_next;
  logic [4:0]     cnt_reg, cnt_next;
  logic [2:0]     op_reg, op_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic [W-1:0]   rem_reg, rem_next;
  logic [W-1:0]   quo_reg, quo_next;
  logic           q_neg_reg, q_neg_next;
  logic           r_neg_reg, r_neg_next;
  logic [W-1:0]   result_reg, result_next;

  logic           a_neg, b_neg;
  logic [W:0]     rem_sh;
  logic [W+1:0]   diff;
  logic           trial_ok;

  // op 001 is the only signed-high product; 011 (illegal) falls through to the low word
  function automatic logic [W-1:0] mul_calc(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb, p;
    ea = (op == 3'b001) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = (op == 3'b001) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    return (op[1:0] == 2'b01 || op[1:0] == 2'b10) ? p[2*W-1:W] : p[W-1:0];
  endfunction

  assign a_neg    = ~in_op[1] & in_a[W-1];
  assign b_neg    = ~in_op[1] & in_b[W-1];
  assign rem_sh   = {rem_reg, quo_reg[W-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, b_reg};
  assign trial_ok = ~diff[W+1];

  assign in_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign out_valid  = (state_reg == DONE);
  assign out_result = result_reg;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    q_neg_next  = q_neg_reg;
    r_neg_next  = r_neg_reg;
    result_next = result_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_next = in_op;
            a_next  = in_a;
            b_next  = in_b;
            if (!in_op[2]) begin
              // A single-cycle multiplier has no pipeline stage to wait in
              if (MUL_LAT == 1) begin
                result_next = mul_calc(in_op, in_a, in_b);
                state_next  = DONE;
              end else begin
                cnt_next   = MUL_CNT_INIT;
                state_next = MUL;
              end
            end else if (in_b == '0) begin
              result_next = in_op[0] ? in_a : '1;
              state_next  = DONE;
            end else begin
              rem_next   = '0;
              quo_next   = a_neg ? -in_a : in_a;
              b_next     = b_neg ? -in_b : in_b;
              q_neg_next = a_neg ^ b_neg;
              r_neg_next = a_neg;
              cnt_next   = DIV_CNT_INIT;
              state_next = DIV_RUN;
            end
          end
        end
        MUL: begin
          cnt_next = cnt_reg - 5'd1;
          if (cnt_reg == 5'd1) begin
            result_next = mul_calc(op_reg, a_reg, b_reg);
            state_next  = DONE;
          end
        end
        DIV_RUN: begin
          // Remainder stays below the divisor, so the untaken path fits in W bits
          rem_next = trial_ok ? diff[W-1:0] : rem_sh[W-1:0];
          quo_next = {quo_reg[W-2:0], trial_ok};
          cnt_next = cnt_reg - 5'd1;
          if (cnt_reg == 5'd0) state_next = DIV_FIX;
        end
        DIV_FIX: begin
          result_next = op_reg[0] ? (r_neg_reg ? -rem_reg : rem_reg)
                                  : (q_neg_reg ? -quo_reg : quo_reg);
          state_next  = DONE;
        end
        DONE: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      q_neg_reg  <= q_neg_next;
      r_neg_reg  <= r_neg_next;
      result_reg <= result_next;
    end
  end

endmodule
